// File: rtl/my_bus_pkg.sv
// rtl/my_bus_pkg.sv - shared types, lock constant and width helpers for the bus arbiter
package my_bus_pkg;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   function automatic logic [31:0] c_lock(input int c_w);
      return (c_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << c_w) - 32'd1);
   endfunction

   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   function automatic int lvl_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/my_bus_arbiter_if.sv
// rtl/my_bus_arbiter_if.sv - N-channel input bus plus single output bus of the arbiter
interface my_bus_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32,
   parameter int C_W    = 2,
   parameter int DEPTH  = 4
) ();
   localparam int CH_W  = my_bus_pkg::ch_width(NUM_CH);
   localparam int LVL_W = my_bus_pkg::lvl_width(DEPTH);

   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH-1:0]        in_ready;
   logic [NUM_CH*DATA_W-1:0] in_a;
   logic [NUM_CH*DATA_W-1:0] in_b;
   logic [NUM_CH*C_W-1:0]    in_c;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_W-1:0]        out_a;
   logic [DATA_W-1:0]        out_b;
   logic [C_W-1:0]           out_c;
   logic [CH_W-1:0]          out_ch;
   logic [NUM_CH*LVL_W-1:0]  level;

   modport slave (
      input  in_valid, in_a, in_b, in_c, out_ready,
      output in_ready, out_valid, out_a, out_b, out_c, out_ch, level
   );

   modport master (
      output in_valid, in_a, in_b, in_c, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_c, out_ch, level
   );

endinterface

// File: rtl/my_bus_chan_fifo.sv
// rtl/my_bus_chan_fifo.sv - per-channel FIFO; a full FIFO refuses push even while popping
module my_bus_chan_fifo #(
   parameter int W     = 66,
   parameter int DEPTH = 4,
   parameter int LVL_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == LVL_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign level   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // DEPTH is a power of two, so pointers wrap naturally
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + LVL_W'(do_push) - LVL_W'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/my_bus_arbiter.sv
// rtl/my_bus_arbiter.sv - buffers N input channels and arbitrates them onto one registered output bus
module my_bus_arbiter
   import my_bus_pkg::*;
#(
   parameter int        NUM_CH   = 4,
   parameter int        DATA_W   = 32,
   parameter int        C_W      = 2,
   parameter int        DEPTH    = 4,
   parameter arb_mode_e ARB_MODE = ARB_RR,
   parameter int        LOCK_EN  = 1
) (
   input  logic             clk,
   input  logic             reset,
   my_bus_arbiter_if.slave  bus
);
   localparam int             CH_W   = ch_width(NUM_CH);
   localparam int             LVL_W  = lvl_width(DEPTH);
   localparam int             BEAT_W = 2 * DATA_W + C_W;
   localparam logic [C_W-1:0] C_LOCK = C_W'(c_lock(C_W));

   logic [NUM_CH-1:0]       push, pop, full, empty;
   logic [BEAT_W-1:0]       head [NUM_CH];
   logic [NUM_CH*LVL_W-1:0] level_all;

   logic                    out_valid_q, out_valid_d;
   logic [DATA_W-1:0]       out_a_q, out_a_d;
   logic [DATA_W-1:0]       out_b_q, out_b_d;
   logic [C_W-1:0]          out_c_q, out_c_d;
   logic [CH_W-1:0]         out_ch_q, out_ch_d;
   logic [CH_W-1:0]         ptr_q, ptr_d;
   logic                    lock_q, lock_d;

   logic                    load_en, grant_valid, locked_grant;
   logic [CH_W-1:0]         grant;
   int                      idx;

   assign bus.in_ready = ~full & {NUM_CH{~reset}};
   assign push         = bus.in_valid & bus.in_ready;
   assign bus.level    = level_all;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      my_bus_chan_fifo #(
         .W     (BEAT_W),
         .DEPTH (DEPTH),
         .LVL_W (LVL_W)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[g]),
         .pop   (pop[g]),
         .din   ({bus.in_a[g*DATA_W +: DATA_W], bus.in_b[g*DATA_W +: DATA_W], bus.in_c[g*C_W +: C_W]}),
         .dout  (head[g]),
         .full  (full[g]),
         .empty (empty[g]),
         .level (level_all[g*LVL_W +: LVL_W])
      );
   end

   // Scans run from the far end down so the highest-priority candidate is assigned last
   always_comb begin
      grant_valid  = 1'b0;
      locked_grant = 1'b0;
      grant        = '0;
      idx          = 0;
      if (lock_q && !empty[out_ch_q]) begin
         grant_valid  = 1'b1;
         locked_grant = 1'b1;
         grant        = out_ch_q;
      end else if (ARB_MODE == ARB_FIXED) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!empty[i]) begin
               grant_valid = 1'b1;
               grant       = CH_W'(i);
            end
         end
      end else begin
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!empty[idx]) begin
               grant_valid = 1'b1;
               grant       = CH_W'(idx);
            end
         end
      end
   end

   assign load_en = !out_valid_q || bus.out_ready;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         pop[i] = load_en && grant_valid && (int'(grant) == i);
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_c_d     = out_c_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      lock_d      = lock_q;
      if (load_en) begin
         out_valid_d = grant_valid;
         lock_d      = 1'b0;
         if (grant_valid) begin
            {out_a_d, out_b_d, out_c_d} = head[grant];
            out_ch_d = grant;
            lock_d   = (LOCK_EN != 0) && (head[grant][C_W-1:0] == C_LOCK);
            // A lock-held grant leaves the pointer where normal arbitration last put it
            if (!locked_grant && ARB_MODE == ARB_RR) begin
               ptr_d = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_c_q     <= '0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
         lock_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_c_q     <= out_c_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
         lock_q      <= lock_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_a     = out_a_q;
   assign bus.out_b     = out_b_q;
   assign bus.out_c     = out_c_q;
   assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_my_bus_arbiter.sv
// tb/tb_my_bus_arbiter.sv - directed bench for round-robin, fixed-priority and no-lock arbiter builds
module tb_my_bus_arbiter;
   import my_bus_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  in_valid;
   logic [127:0] in_a, in_b;
   logic [7:0]  in_c;
   logic        out_ready;

   int n_chk = 0;
   int n_err = 0;

   int          q_ch_rr[$], q_ch_fx[$], q_ch_nl[$];
   logic [31:0] q_a_rr[$], q_a_fx[$];

   int exp_rr_ch[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
   int exp_fx_ch[8]   = '{0, 0, 1, 1, 2, 2, 3, 3};
   int exp_rr_a[8]    = '{'h000, 'h100, 'h200, 'h300, 'h001, 'h101, 'h201, 'h301};
   int exp_fx_a[8]    = '{'h000, 'h001, 'h100, 'h101, 'h200, 'h201, 'h300, 'h301};
   int exp_bp_a[6]    = '{'hB0, 'hA0, 'hA1, 'hA2, 'hA3, 'hA4};
   int exp_bp_ch[6]   = '{1, 0, 0, 0, 0, 0};
   int exp_lk_ch[5]   = '{1, 1, 1, 0, 0};
   int exp_lk_a[5]    = '{'h11, 'h12, 'h13, 'h01, 'h02};
   int exp_nl_ch[5]   = '{1, 0, 1, 0, 1};

   always #5 clk = ~clk;

   my_bus_arbiter_if #(.NUM_CH(4), .DATA_W(32), .C_W(2), .DEPTH(4)) bus_rr ();
   my_bus_arbiter_if #(.NUM_CH(4), .DATA_W(32), .C_W(2), .DEPTH(4)) bus_fx ();
   my_bus_arbiter_if #(.NUM_CH(4), .DATA_W(32), .C_W(2), .DEPTH(4)) bus_nl ();

   assign bus_rr.in_valid = in_valid;  assign bus_fx.in_valid = in_valid;  assign bus_nl.in_valid = in_valid;
   assign bus_rr.in_a = in_a;          assign bus_fx.in_a = in_a;          assign bus_nl.in_a = in_a;
   assign bus_rr.in_b = in_b;          assign bus_fx.in_b = in_b;          assign bus_nl.in_b = in_b;
   assign bus_rr.in_c = in_c;          assign bus_fx.in_c = in_c;          assign bus_nl.in_c = in_c;
   assign bus_rr.out_ready = out_ready; assign bus_fx.out_ready = out_ready; assign bus_nl.out_ready = out_ready;

   my_bus_arbiter #(.NUM_CH(4), .DATA_W(32), .C_W(2), .DEPTH(4), .ARB_MODE(ARB_RR), .LOCK_EN(1))
      dut_rr (.clk(clk), .reset(reset), .bus(bus_rr));
   my_bus_arbiter #(.NUM_CH(4), .DATA_W(32), .C_W(2), .DEPTH(4), .ARB_MODE(ARB_FIXED), .LOCK_EN(1))
      dut_fx (.clk(clk), .reset(reset), .bus(bus_fx));
   my_bus_arbiter #(.NUM_CH(4), .DATA_W(32), .C_W(2), .DEPTH(4), .ARB_MODE(ARB_RR), .LOCK_EN(0))
      dut_nl (.clk(clk), .reset(reset), .bus(bus_nl));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] lvl(input logic [11:0] v, input int ch);
      return v[ch*3 +: 3];
   endfunction

   task automatic set_beat(input int ch, input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
      in_a[ch*32 +: 32] = a;
      in_b[ch*32 +: 32] = b;
      in_c[ch*2 +: 2]   = c;
   endtask

   task automatic do_reset(input int n);
      reset     = 1'b1;
      in_valid  = '0;
      out_ready = 1'b0;
      repeat (n) tick();
      reset = 1'b0;
      #1;
   endtask

   // Accepts beats with out_ready high; a held ch0 push is dropped once it fires
   task automatic drain(input int n, input int budget);
      int  cyc;
      logic fire;
      cyc = 0;
      q_ch_rr.delete(); q_ch_fx.delete(); q_ch_nl.delete();
      q_a_rr.delete();  q_a_fx.delete();
      out_ready = 1'b1;
      while ((q_ch_rr.size() < n || q_ch_fx.size() < n || q_ch_nl.size() < n) && cyc < budget) begin
         if (bus_rr.out_valid) begin q_ch_rr.push_back(int'(bus_rr.out_ch)); q_a_rr.push_back(bus_rr.out_a); end
         if (bus_fx.out_valid) begin q_ch_fx.push_back(int'(bus_fx.out_ch)); q_a_fx.push_back(bus_fx.out_a); end
         if (bus_nl.out_valid) q_ch_nl.push_back(int'(bus_nl.out_ch));
         fire = in_valid[0] & bus_rr.in_ready[0];
         tick();
         cyc++;
         if (fire) in_valid[0] = 1'b0;
      end
   endtask

   initial begin
      int stale;
      reset = 1'b1; in_valid = '0; in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b0;

      // reset / idle
      repeat (3) tick();
      check_eq("rst_in_ready", bus_rr.in_ready, 4'h0);
      check_eq("rst_out_valid", bus_rr.out_valid, 0);
      check_eq("rst_level", bus_rr.level, 0);
      check_eq("rst_out_a_ch", {bus_rr.out_a, 30'd0, bus_rr.out_ch}, 0);
      reset = 1'b0;
      #1;
      check_eq("post_rst_in_ready", bus_rr.in_ready, 4'hF);

      // latency
      set_beat(2, 32'h11, 32'h22, 2'd0);
      in_valid = 4'b0100; out_ready = 1'b1;
      tick();
      in_valid = '0;
      check_eq("lat_e0_valid", bus_rr.out_valid, 0);
      check_eq("lat_e0_level2", lvl(bus_rr.level, 2), 1);
      tick();
      check_eq("lat_e1_valid", bus_rr.out_valid, 1);
      check_eq("lat_e1_a", bus_rr.out_a, 32'h11);
      check_eq("lat_e1_b", bus_rr.out_b, 32'h22);
      check_eq("lat_e1_ch", bus_rr.out_ch, 2);
      check_eq("lat_e1_level2", lvl(bus_rr.level, 2), 0);
      tick();
      check_eq("lat_e2_valid", bus_rr.out_valid, 0);

      // round-robin vs fixed priority
      do_reset(1);
      for (int j = 0; j < 2; j++) begin
         for (int ch = 0; ch < 4; ch++) set_beat(ch, 32'h100 * ch + j, 32'h0, 2'd0);
         in_valid = 4'hF;
         tick();
      end
      in_valid = '0;
      drain(8, 40);
      check_eq("rr_count", q_ch_rr.size(), 8);
      check_eq("fx_count", q_ch_fx.size(), 8);
      for (int k = 0; k < 8; k++) begin
         check_eq($sformatf("rr_ch[%0d]", k), (k < q_ch_rr.size()) ? q_ch_rr[k] : -1, exp_rr_ch[k]);
         check_eq($sformatf("rr_a[%0d]", k), (k < q_a_rr.size()) ? q_a_rr[k] : 32'hDEAD, exp_rr_a[k]);
         check_eq($sformatf("fx_ch[%0d]", k), (k < q_ch_fx.size()) ? q_ch_fx[k] : -1, exp_fx_ch[k]);
         check_eq($sformatf("fx_a[%0d]", k), (k < q_a_fx.size()) ? q_a_fx[k] : 32'hDEAD, exp_fx_a[k]);
      end

      // backpressure and full FIFO
      do_reset(1);
      set_beat(1, 32'hB0, 32'h0, 2'd0);
      in_valid = 4'b0010;
      tick();
      in_valid = '0;
      tick();
      check_eq("bp_hold_valid", bus_rr.out_valid, 1);
      for (int j = 0; j < 4; j++) begin
         set_beat(0, 32'hA0 + j, 32'h0, 2'd0);
         in_valid = 4'b0001;
         tick();
      end
      set_beat(0, 32'hA4, 32'h0, 2'd0);
      check_eq("bp_full_ready", bus_rr.in_ready[0], 0);
      check_eq("bp_full_level", lvl(bus_rr.level, 0), 4);
      tick(); tick();
      check_eq("bp_stall_level", lvl(bus_rr.level, 0), 4);
      check_eq("bp_stall_a", bus_rr.out_a, 32'hB0);
      check_eq("bp_stall_ch", bus_rr.out_ch, 1);
      drain(6, 40);
      check_eq("bp_count", q_a_rr.size(), 6);
      for (int k = 0; k < 6; k++) begin
         check_eq($sformatf("bp_a[%0d]", k), (k < q_a_rr.size()) ? q_a_rr[k] : 32'hDEAD, exp_bp_a[k]);
         check_eq($sformatf("bp_ch[%0d]", k), (k < q_ch_rr.size()) ? q_ch_rr[k] : -1, exp_bp_ch[k]);
      end
      check_eq("bp_level_end", lvl(bus_rr.level, 0), 0);

      // burst lock; one ch0 beat first moves the pointer to 1
      do_reset(1);
      set_beat(0, 32'hC0, 32'h0, 2'd0);
      in_valid = 4'b0001; out_ready = 1'b1;
      tick();
      in_valid = '0;
      tick(); tick();
      out_ready = 1'b0;
      set_beat(1, 32'h11, 32'h0, 2'd3); set_beat(0, 32'h01, 32'h0, 2'd0);
      in_valid = 4'b0011;
      tick();
      set_beat(1, 32'h12, 32'h0, 2'd3); set_beat(0, 32'h02, 32'h0, 2'd0);
      tick();
      set_beat(1, 32'h13, 32'h0, 2'd0);
      in_valid = 4'b0010;
      tick();
      in_valid = '0;
      drain(5, 40);
      check_eq("lk_count", q_ch_rr.size(), 5);
      check_eq("nl_count", q_ch_nl.size(), 5);
      for (int k = 0; k < 5; k++) begin
         check_eq($sformatf("lk_ch[%0d]", k), (k < q_ch_rr.size()) ? q_ch_rr[k] : -1, exp_lk_ch[k]);
         check_eq($sformatf("lk_a[%0d]", k), (k < q_a_rr.size()) ? q_a_rr[k] : 32'hDEAD, exp_lk_a[k]);
         check_eq($sformatf("nl_ch[%0d]", k), (k < q_ch_nl.size()) ? q_ch_nl[k] : -1, exp_nl_ch[k]);
      end

      // reset in the middle of traffic
      do_reset(1);
      for (int j = 0; j < 4; j++) begin
         set_beat(3, 32'hD0 + j, 32'h0, 2'd0);
         in_valid = 4'b1000;
         tick();
      end
      in_valid = '0;
      check_eq("mr_level3", lvl(bus_rr.level, 3), 3);
      check_eq("mr_valid", bus_rr.out_valid, 1);
      reset = 1'b1;
      tick();
      check_eq("mr_rst_valid", bus_rr.out_valid, 0);
      check_eq("mr_rst_level3", lvl(bus_rr.level, 3), 0);
      check_eq("mr_rst_in_ready", bus_rr.in_ready, 4'h0);
      reset = 1'b0; out_ready = 1'b1;
      #1;
      check_eq("mr_in_ready", bus_rr.in_ready, 4'hF);
      stale = 0;
      repeat (10) begin
         tick();
         if (bus_rr.out_valid) stale++;
      end
      check_eq("mr_stale", stale, 0);
      check_eq("mr_level_end", bus_rr.level, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/my_bus_arbiter.md
Name: my_bus_arbiter

Overview:
- Parametrised N-channel successor of the single-channel valid/a/b/c bus.
- Adds valid/ready backpressure, per-channel buffering and arbitration onto one output bus.
- Each channel owns a DEPTH-entry FIFO of {a,b,c} transactions.
- The arbiter loads a registered output stage. It tags each beat with its source channel and can hold a grant across locked bursts.

Parameters:
- NUM_CH, 4: number of input channels, 2..16.
- DATA_W, 32: width of the a and b fields.
- C_W, 2: width of the c control field.
- DEPTH, 4: entries per channel FIFO; power of two, >=2.
- ARB_MODE, ARB_RR: ARB_RR = round-robin; ARB_FIXED = lowest index wins.
- LOCK_EN, 1: 1 enables burst lock on c == C_LOCK (all ones).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready (= FIFO not full).
- in_a  in  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W].
- in_b  in  NUM_CH*DATA_W  same packing as in_a.
- in_c  in  NUM_CH*C_W  same packing.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_a  out  DATA_W  output a field.
- out_b  out  DATA_W  output b field.
- out_c  out  C_W  output c field.
- out_ch  out  CH_W  source channel; CH_W = max(1,$clog2(NUM_CH)).
- level  out  NUM_CH*LVL_W  per-channel occupancy; LVL_W = $clog2(DEPTH+1).

Behaviour:
- Reset, while high:
  - all FIFOs emptied, level = 0.
  - out_valid = 0; out_a/out_b/out_c/out_ch = 0.
  - RR pointer = 0, lock cleared.
  - in_ready = 0.
- First cycle after reset low: in_ready = all ones.
- Reset mid-operation: all buffered and in-flight beats are discarded; there is no flush handshake.
- Push: at the edge where in_valid[i] & in_ready[i], append {a,b,c} to FIFO i.
- Full FIFO: in_ready[i] depends on full only. A full FIFO refuses a push even in a cycle where it pops.
- Output register is loadable when !out_valid || out_ready.
- Load: if loadable and any FIFO is non-empty, pop the granted channel and register its head beat plus out_ch. out_valid = 1 after that edge.
- No load (loadable, all FIFOs empty): out_valid = 0 after the edge.
- Latency: a beat pushed at edge E0 can appear on out_* after E1 at the earliest. There is no bypass path.
- Back-to-back: with out_ready held high, one beat per cycle.
- Stall: while out_valid & !out_ready, out_* stay stable and no pop occurs.
- ARB_RR grant: first non-empty channel scanning from ptr upward, wrapping. After a grant to k, ptr = (k+1) mod NUM_CH.
- ARB_FIXED grant: lowest-index non-empty channel.
- Lock (LOCK_EN = 1):
  - If the beat just loaded has c == C_LOCK, the next load grants the same channel if it is non-empty.
  - If that channel is empty at the next load opportunity, the lock releases and normal arbitration applies.
  - The RR pointer is not advanced while locked.
- Simultaneous push and pop on the same FIFO: level is unchanged and ordering is preserved.
- level[i] is updated at the same edge as the push/pop.
- Width rule: every field passes through unmodified.

Decomposition:
- Package my_bus_pkg holds:
  - the arb_mode_e enum (ARB_RR, ARB_FIXED);
  - the C_LOCK helper function (all-ones of C_W);
  - a function for the CH_W/LVL_W calculations.
- Sub-module my_bus_chan_fifo (parametrised on width and depth):
  - ports: push, pop, data in/out, full, empty, level;
  - instanced NUM_CH times through a generate loop.
- Arbiter, lock logic and output register live in the top module.

Test Plan:
- Reset/idle: reset high 3 cycles, then low -> during reset in_ready = 0000, out_valid = 0, level all 0; first cycle after release in_ready = 1111.
- Latency: push ch2 a=0x11 b=0x22 c=0 at E0, out_ready = 1 -> out_valid rises after E1 with out_a=0x11, out_b=0x22, out_ch=2.
- Round-robin: channels 0..3 each hold 2 beats, out_ready = 1 -> out_ch sequence 0,1,2,3,0,1,2,3. Same stimulus with ARB_FIXED -> 0,0,1,1,2,2,3,3.
- Backpressure/full: out_ready = 0, push 5 beats on ch0 -> in_ready[0] = 0 after the 4th; level[0] = 4; out_* stable. Raise out_ready -> all 4 beats emerge in order, 5th accepted once in_ready[0] returns to 1.
- Lock: ch1 beats c = 3,3,0; ch0 has 2 beats; ptr=1 -> out_ch sequence 1,1,1,0,0. With LOCK_EN = 0 -> 1,0,1,0,1.
- Mid-operation reset: 3 beats in ch3 and out_valid high; pulse reset 1 cycle -> out_valid = 0, level[3] = 0; no stale beat appears afterwards.
